// File: rtl/cache_mem_scheduler_pkg.sv
// Shared definitions for the cache/memory scheduler: FSM state encoding,
// transfer-direction and boolean constants, and requester IDs used to index
// the two-bit request/grant vectors.
package cache_mem_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERV_IC = 2'd1,
    SERV_DC = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned REQ_IC = 0;
  localparam int unsigned REQ_DC = 1;

endpackage

// File: rtl/rr_grant2.sv
// Two-input round-robin picker.
//   i_Req        : request vector, bit REQ_IC / bit REQ_DC
//   i_Last_Grant : requester ID that owned the previous burst
//   o_Grant      : one-hot grant (all zero when nobody requests)
module rr_grant2
  import cache_mem_scheduler_pkg::*;
(
  input  logic [1:0] i_Req,
  input  logic       i_Last_Grant,
  output logic [1:0] o_Grant
);

  // On contention the requester that did not own the last burst wins.
  always_comb begin
    o_Grant = 2'b00;
    case (i_Req)
      2'b01:   o_Grant = 2'b01;
      2'b10:   o_Grant = 2'b10;
      2'b11:   o_Grant = (i_Last_Grant == 1'(REQ_DC)) ? 2'b01 : 2'b10;
      default: o_Grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_mem_scheduler.sv
// Shares the arbiter's single CORE port between the I-cache refill engine
// (read only) and the D-cache refill/writeback engine. One burst is owned
// end to end; beats are counted and a length mismatch raises a sticky error.
// Ports:
//   i_Clk, i_Reset_n                         clock, async active-low reset
//   i_IC_* / o_IC_*                          I-cache line-read request/beats
//   i_DC_* / o_DC_*                          D-cache read/writeback request/beats
//   o_MEM_* / i_MEM_*                        arbiter CORE port
//   o_Burst_Error                            sticky beat-count mismatch flag
module cache_mem_scheduler
  import cache_mem_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 21,
  parameter int unsigned BURST_LEN     = 8,
  parameter int unsigned CNT_WIDTH     = 3
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_IC_Valid,
  input  logic [ADDRESS_WIDTH-1:0] i_IC_Address,
  output logic                     o_IC_Valid,
  output logic [DATA_WIDTH-1:0]    o_IC_Data,
  output logic                     o_IC_Last,
  input  logic                     i_DC_Valid,
  input  logic                     i_DC_Read_Write_n,
  input  logic [ADDRESS_WIDTH-1:0] i_DC_Address,
  input  logic [DATA_WIDTH-1:0]    i_DC_Data,
  output logic                     o_DC_Valid,
  output logic                     o_DC_Data_Read,
  output logic [DATA_WIDTH-1:0]    o_DC_Data,
  output logic                     o_DC_Last,
  output logic                     o_MEM_Valid,
  output logic                     o_MEM_Read_Write_n,
  output logic [ADDRESS_WIDTH-1:0] o_MEM_Address,
  output logic [DATA_WIDTH-1:0]    o_MEM_Data,
  input  logic                     i_MEM_Valid,
  input  logic                     i_MEM_Data_Read,
  input  logic                     i_MEM_Last,
  input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
  output logic                     o_Burst_Error
);

  localparam logic [CNT_WIDTH-1:0] C_LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  state_t               r_State, w_State_Next;
  logic                 r_Last_Grant, w_Last_Grant_Next;
  logic [CNT_WIDTH-1:0] r_Beat_Cnt, w_Beat_Cnt_Next;
  logic                 r_Burst_Error, w_Burst_Error_Next;
  logic [1:0]           w_Req;
  logic [1:0]           w_Grant;
  logic                 w_Beat;

  assign w_Req         = {i_DC_Valid, i_IC_Valid};
  assign o_Burst_Error = r_Burst_Error;

  rr_grant2 u_rr_grant2 (
    .i_Req        (w_Req),
    .i_Last_Grant (r_Last_Grant),
    .o_Grant      (w_Grant)
  );

  // State, round-robin pointer, beat counter and sticky error.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_State       <= IDLE;
      r_Last_Grant  <= 1'(REQ_DC);
      r_Beat_Cnt    <= '0;
      r_Burst_Error <= FALSE;
    end else begin
      r_State       <= w_State_Next;
      r_Last_Grant  <= w_Last_Grant_Next;
      r_Beat_Cnt    <= w_Beat_Cnt_Next;
      r_Burst_Error <= w_Burst_Error_Next;
    end
  end

  // Next-state and pass-through decode from the registered owner.
  always_comb begin
    w_State_Next       = r_State;
    w_Last_Grant_Next  = r_Last_Grant;
    w_Beat_Cnt_Next    = r_Beat_Cnt;
    w_Burst_Error_Next = r_Burst_Error;
    w_Beat             = FALSE;
    o_IC_Valid         = FALSE;
    o_IC_Data          = '0;
    o_IC_Last          = FALSE;
    o_DC_Valid         = FALSE;
    o_DC_Data_Read     = FALSE;
    o_DC_Data          = '0;
    o_DC_Last          = FALSE;
    o_MEM_Valid        = FALSE;
    o_MEM_Read_Write_n = READ;
    o_MEM_Address      = '0;
    o_MEM_Data         = '0;

    case (r_State)
      IDLE: begin
        if (w_Grant[REQ_IC]) begin
          w_State_Next    = SERV_IC;
          w_Beat_Cnt_Next = '0;
        end else if (w_Grant[REQ_DC]) begin
          w_State_Next    = SERV_DC;
          w_Beat_Cnt_Next = '0;
        end
      end
      SERV_IC: begin
        o_MEM_Valid   = TRUE;
        o_MEM_Address = i_IC_Address;
        o_IC_Valid    = i_MEM_Valid;
        o_IC_Data     = i_MEM_Data;
        o_IC_Last     = i_MEM_Last;
        w_Beat        = i_MEM_Valid;
      end
      SERV_DC: begin
        o_MEM_Valid        = TRUE;
        o_MEM_Read_Write_n = i_DC_Read_Write_n;
        o_MEM_Address      = i_DC_Address;
        o_MEM_Data         = i_DC_Data;
        o_DC_Valid         = i_MEM_Valid;
        o_DC_Data_Read     = i_MEM_Data_Read;
        o_DC_Data          = i_MEM_Data;
        o_DC_Last          = i_MEM_Last;
        w_Beat             = (i_DC_Read_Write_n == READ) ? i_MEM_Valid : i_MEM_Data_Read;
      end
      DRAIN:   w_State_Next = IDLE;
      default: w_State_Next = IDLE;
    endcase

    // Burst accounting; Last ends the burst even without a beat strobe.
    if ((r_State == SERV_IC) || (r_State == SERV_DC)) begin
      if (i_MEM_Last) begin
        w_State_Next      = DRAIN;
        w_Last_Grant_Next = (r_State == SERV_DC);
        w_Beat_Cnt_Next   = '0;
        if (!w_Beat || (r_Beat_Cnt != C_LAST_BEAT)) begin
          w_Burst_Error_Next = TRUE;
        end
      end else if (w_Beat) begin
        w_Beat_Cnt_Next = (r_Beat_Cnt == C_LAST_BEAT) ? '0 : r_Beat_Cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_scheduler.sv
// Randomized self-checking bench for cache_mem_scheduler with a
// transaction-level model of grant order and sticky burst-length error.
module tb_cache_mem_scheduler;

  localparam int DW = 32;
  localparam int AW = 21;
  localparam int BL = 8;

  logic          i_Clk = 1'b0;
  logic          i_Reset_n;
  logic          i_IC_Valid;
  logic [AW-1:0] i_IC_Address;
  logic          o_IC_Valid;
  logic [DW-1:0] o_IC_Data;
  logic          o_IC_Last;
  logic          i_DC_Valid;
  logic          i_DC_Read_Write_n;
  logic [AW-1:0] i_DC_Address;
  logic [DW-1:0] i_DC_Data;
  logic          o_DC_Valid;
  logic          o_DC_Data_Read;
  logic [DW-1:0] o_DC_Data;
  logic          o_DC_Last;
  logic          o_MEM_Valid;
  logic          o_MEM_Read_Write_n;
  logic [AW-1:0] o_MEM_Address;
  logic [DW-1:0] o_MEM_Data;
  logic          i_MEM_Valid;
  logic          i_MEM_Data_Read;
  logic          i_MEM_Last;
  logic [DW-1:0] i_MEM_Data;
  logic          o_Burst_Error;

  int n_total = 0;
  int n_bad   = 0;
  bit m_ptr_dc;   // model: last burst owner was the D-cache
  bit m_err;      // model: sticky error

  cache_mem_scheduler dut (
    .i_Clk              (i_Clk),
    .i_Reset_n          (i_Reset_n),
    .i_IC_Valid         (i_IC_Valid),
    .i_IC_Address       (i_IC_Address),
    .o_IC_Valid         (o_IC_Valid),
    .o_IC_Data          (o_IC_Data),
    .o_IC_Last          (o_IC_Last),
    .i_DC_Valid         (i_DC_Valid),
    .i_DC_Read_Write_n  (i_DC_Read_Write_n),
    .i_DC_Address       (i_DC_Address),
    .i_DC_Data          (i_DC_Data),
    .o_DC_Valid         (o_DC_Valid),
    .o_DC_Data_Read     (o_DC_Data_Read),
    .o_DC_Data          (o_DC_Data),
    .o_DC_Last          (o_DC_Last),
    .o_MEM_Valid        (o_MEM_Valid),
    .o_MEM_Read_Write_n (o_MEM_Read_Write_n),
    .o_MEM_Address      (o_MEM_Address),
    .o_MEM_Data         (o_MEM_Data),
    .i_MEM_Valid        (i_MEM_Valid),
    .i_MEM_Data_Read    (i_MEM_Data_Read),
    .i_MEM_Last         (i_MEM_Last),
    .i_MEM_Data         (i_MEM_Data),
    .o_Burst_Error      (o_Burst_Error)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    i_MEM_Valid     = 1'b0;
    i_MEM_Data_Read = 1'b0;
    i_MEM_Last      = 1'b0;
    i_MEM_Data      = '0;
  endtask

  // One request phase plus one owned burst. Entered and left at posedge+1
  // with the scheduler idle. rst_at >= 0 pulls reset at that beat index.
  task automatic run_burst(input bit req_ic, input bit req_dc, input bit dc_rd,
                           input logic [AW-1:0] ic_a, input logic [AW-1:0] dc_a,
                           input int n_beats, input bit gaps, input bit drop,
                           input int rst_at);
    bit g_dc, beat, last;
    int k, gap_run;
    logic [DW-1:0] rd, wd;
    // request cycle, with a possible stray memory strobe that must be ignored
    i_IC_Valid        = req_ic;
    i_DC_Valid        = req_dc;
    i_DC_Read_Write_n = dc_rd;
    i_IC_Address      = ic_a;
    i_DC_Address      = dc_a;
    wd                = 32'hA0;
    i_DC_Data         = wd;
    clear_mem();
    i_MEM_Valid       = 1'($urandom_range(0, 1));
    i_MEM_Data        = $urandom;
    #1;
    chk("idle_mem_valid", o_MEM_Valid, 0);
    chk("idle_fwd", {o_IC_Valid, o_DC_Valid, o_IC_Data, o_DC_Data}, 0);
    chk("idle_rw", o_MEM_Read_Write_n, 1);
    g_dc = (req_ic && req_dc) ? !m_ptr_dc : req_dc;
    @(posedge i_Clk); #1;
    k = 0;
    gap_run = 0;
    while (k < n_beats) begin
      beat    = !gaps || (gap_run >= 2) || ($urandom_range(0, 2) != 0);
      gap_run = beat ? 0 : gap_run + 1;
      last    = beat && (k == n_beats - 1);
      rd      = $urandom;
      i_MEM_Data      = rd;
      i_MEM_Valid     = beat && (!g_dc || dc_rd);
      i_MEM_Data_Read = beat && g_dc && !dc_rd;
      i_MEM_Last      = last;
      if (drop && k == 3) begin
        if (g_dc) i_DC_Valid = 1'b0;
        else      i_IC_Valid = 1'b0;
      end
      if (k == rst_at) begin
        i_Reset_n = 1'b0;
        #1;
        chk("rst_mem_valid", o_MEM_Valid, 0);
        chk("rst_fwd", {o_IC_Valid, o_DC_Valid, o_DC_Data_Read, o_IC_Last, o_DC_Last}, 0);
        chk("rst_rw", o_MEM_Read_Write_n, 1);
        chk("rst_addr", o_MEM_Address, 0);
        chk("rst_data", {o_IC_Data, o_DC_Data}, 0);
        chk("rst_mem_data", o_MEM_Data, 0);
        chk("rst_err", o_Burst_Error, 0);
        m_ptr_dc = 1'b1;
        m_err    = 1'b0;
        i_IC_Valid = 1'b0;
        i_DC_Valid = 1'b0;
        clear_mem();
        @(posedge i_Clk); #1;
        chk("rst_hold", o_MEM_Valid, 0);
        i_Reset_n = 1'b1;
        return;
      end
      #1;
      chk("serv_mem_valid", o_MEM_Valid, 1);
      chk("serv_addr", o_MEM_Address, g_dc ? dc_a : ic_a);
      chk("serv_rw", o_MEM_Read_Write_n, g_dc ? dc_rd : 1'b1);
      if (!g_dc) begin
        chk("ic_valid", o_IC_Valid, beat);
        chk("ic_data", o_IC_Data, rd);
        chk("ic_last", o_IC_Last, last);
        chk("ic_other", {o_DC_Valid, o_DC_Last, o_DC_Data_Read}, 0);
      end else if (dc_rd) begin
        chk("dc_valid", o_DC_Valid, beat);
        chk("dc_data", o_DC_Data, rd);
        chk("dc_last", o_DC_Last, last);
        chk("dc_other", {o_IC_Valid, o_IC_Last}, 0);
      end else begin
        chk("dc_wr_strobe", o_DC_Data_Read, beat);
        chk("dc_wr_data", o_MEM_Data, wd);
        chk("dc_wr_last", o_DC_Last, last);
        chk("dc_wr_other", {o_IC_Valid, o_IC_Last}, 0);
      end
      @(posedge i_Clk); #1;
      if (beat) begin
        k++;
        if (g_dc && !dc_rd) begin
          wd++;
          i_DC_Data = wd;
        end
      end
    end
    // dead cycle: owner releases, stray strobes must not be forwarded
    if (g_dc) i_DC_Valid = 1'b0;
    else      i_IC_Valid = 1'b0;
    clear_mem();
    i_MEM_Valid = 1'($urandom_range(0, 1));
    m_ptr_dc = g_dc;
    if (((n_beats - 1) % BL) != BL - 1) m_err = 1'b1;
    #1;
    chk("drain_mem_valid", o_MEM_Valid, 0);
    chk("drain_fwd", {o_IC_Valid, o_DC_Valid}, 0);
    chk("burst_err", o_Burst_Error, m_err);
    @(posedge i_Clk); #1;
    i_MEM_Valid = 1'b0;
  endtask

  initial begin
    i_Reset_n         = 1'b0;
    i_IC_Valid        = 1'b0;
    i_IC_Address      = '0;
    i_DC_Valid        = 1'b0;
    i_DC_Read_Write_n = 1'b1;
    i_DC_Address      = '0;
    i_DC_Data         = '0;
    clear_mem();
    m_ptr_dc = 1'b1;
    m_err    = 1'b0;
    #2;
    chk("reset_mem_valid", o_MEM_Valid, 0);
    chk("reset_rw", o_MEM_Read_Write_n, 1);
    chk("reset_addr", o_MEM_Address, 0);
    chk("reset_err", o_Burst_Error, 0);
    chk("reset_fwd", {o_IC_Valid, o_DC_Valid, o_DC_Data_Read, o_IC_Last, o_DC_Last}, 0);
    repeat (3) @(posedge i_Clk);
    #1;
    i_Reset_n = 1'b1;

    // lone I-cache line read, back-to-back beats
    run_burst(1, 0, 1, 21'h1F000, '0, 8, 0, 0, -1);
    // both requesting: strict alternation
    repeat (6) run_burst(1, 1, 1, AW'($urandom), AW'($urandom), 8, 1, 0, -1);
    // D-cache writeback, data 0xA0..0xA7
    run_burst(0, 1, 0, '0, AW'($urandom), 8, 0, 0, -1);
    // random traffic; 16-beat bursts land on the counter wrap
    for (int i = 0; i < 30; i++) begin
      bit ric, rdc;
      ric = 1'($urandom_range(0, 1));
      rdc = 1'($urandom_range(0, 1));
      if (!ric && !rdc) ric = 1'b1;
      run_burst(ric, rdc, 1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom),
                ($urandom_range(0, 4) == 0) ? 16 : 8, 1, ($urandom_range(0, 3) == 0), -1);
    end
    // short burst raises the sticky error; good bursts keep it
    run_burst(1, 0, 1, AW'($urandom), '0, 6, 1, 0, -1);
    run_burst(0, 1, 1, '0, AW'($urandom), 8, 1, 0, -1);
    run_burst(1, 1, 0, AW'($urandom), AW'($urandom), 8, 1, 0, -1);
    // owner drops its request mid-burst
    run_burst(0, 1, 1, '0, AW'($urandom), 8, 1, 1, -1);
    // reset at beat 4 of a D-cache read, then contention goes to the I-cache
    run_burst(0, 1, 1, '0, AW'($urandom), 8, 0, 0, 4);
    run_burst(1, 1, 1, AW'($urandom), AW'($urandom), 8, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_scheduler.md
Name: cache_mem_scheduler

Overview:
Shares the single CORE port of the memory arbiter between the instruction-cache refill engine (read-only) and the data-cache refill/writeback engine (read/write). Requests are granted round-robin; one burst is owned end-to-end. Beats are counted against the expected burst length, and a mismatch is flagged. Sits between the two cache controllers and memory_arbiter's i_CORE_*/o_CORE_* ports.

Parameters:
DATA_WIDTH, 32, beat data width
ADDRESS_WIDTH, 21, core word-pair address width (matches CORE_ADDRESS_WIDTH downstream)
BURST_LEN, 8, beats per cache-line transaction
CNT_WIDTH, 3, width of beat counter, equal to clog2(BURST_LEN)

Ports:
i_Clk  in  1  clock
i_Reset_n  in  1  asynchronous, active-low reset
i_IC_Valid  in  1  I-cache line-read request; held until o_IC_Last
i_IC_Address  in  ADDRESS_WIDTH  I-cache line base address
o_IC_Valid  out  1  read beat valid to I-cache
o_IC_Data  out  DATA_WIDTH  read beat data
o_IC_Last  out  1  final beat of I-cache burst
i_DC_Valid  in  1  D-cache request; held until o_DC_Last
i_DC_Read_Write_n  in  1  1 = line read, 0 = line writeback
i_DC_Address  in  ADDRESS_WIDTH  D-cache line base address
i_DC_Data  in  DATA_WIDTH  writeback beat data
o_DC_Valid  out  1  read beat valid to D-cache
o_DC_Data_Read  out  1  current write beat consumed; advance i_DC_Data
o_DC_Data  out  DATA_WIDTH  read beat data
o_DC_Last  out  1  final beat of D-cache burst
o_MEM_Valid  out  1  to arbiter i_CORE_Valid
o_MEM_Read_Write_n  out  1  to arbiter i_CORE_Read_Write_n
o_MEM_Address  out  ADDRESS_WIDTH  to arbiter i_CORE_Address
o_MEM_Data  out  DATA_WIDTH  to arbiter i_CORE_Data
i_MEM_Valid  in  1  from arbiter o_CORE_Valid
i_MEM_Data_Read  in  1  from arbiter o_CORE_Data_Read
i_MEM_Last  in  1  from arbiter o_CORE_Last
i_MEM_Data  in  DATA_WIDTH  from arbiter o_CORE_Data
o_Burst_Error  out  1  sticky flag for beat-count mismatch

Behaviour:
- States: IDLE, SERV_IC, SERV_DC, DRAIN. State is registered; all outputs are decoded combinationally from the registered state and the inputs.
- Reset values:
  - State = IDLE, last-grant pointer = DC, beat counter = 0, o_Burst_Error = 0.
  - All valid, last and read strobes = 0.
  - o_MEM_Read_Write_n = 1.
  - Data and address outputs = 0.
- IDLE:
  - Only IC valid → SERV_IC. Only DC valid → SERV_DC.
  - Both valid → grant the requester not named by the pointer. After reset with both valid, IC wins.
  - Grant is visible one cycle after the request is seen. No o_MEM_Valid is driven in IDLE.
- SERV_IC:
  - o_MEM_Valid = 1, o_MEM_Read_Write_n = 1, o_MEM_Address = i_IC_Address.
  - o_IC_Valid / o_IC_Data / o_IC_Last pass through from i_MEM_Valid / i_MEM_Data / i_MEM_Last.
- SERV_DC:
  - o_MEM_Valid = 1; o_MEM_Read_Write_n = i_DC_Read_Write_n; address and data pass through.
  - o_DC_Valid / o_DC_Data_Read / o_DC_Data / o_DC_Last pass through.
- Beat accounting:
  - A beat is i_MEM_Valid (read) or i_MEM_Data_Read (write) while in a SERV state.
  - The counter increments on each beat, wraps modulo BURST_LEN, and clears on entry to a SERV state.
- Burst end:
  - i_MEM_Last on a beat → set the pointer to the served requester, go to DRAIN, clear the counter.
  - If the counter ≠ BURST_LEN-1 at i_MEM_Last, set o_Burst_Error; it clears only on reset.
  - i_MEM_Last with no beat strobe is also an error; the scheduler still goes to DRAIN.
- DRAIN: exactly one dead cycle with o_MEM_Valid = 0, so the downstream arbiter returns to ready. Then → IDLE.
- Simultaneous requests: IC and DC alternate strictly, so neither starves.
- A requester dropping Valid mid-burst is ignored. The burst runs to i_MEM_Last, and outputs still pass through.
- Memory strobes arriving in IDLE/DRAIN are ignored; they are not forwarded or counted.
- Reset mid-burst:
  - Immediate return to IDLE; all outputs take their reset values.
  - The in-flight burst is abandoned; the downstream blocks are reset together.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE, SERV_IC, SERV_DC, DRAIN, 2-bit);
  - READ/WRITE and TRUE/FALSE constants;
  - requester IDs REQ_IC = 0, REQ_DC = 1.
- One natural sub-module, rr_grant2: 2-input round-robin picker (requests + pointer → one-hot grant). Everything else stays in the top module.

Test Plan:
- IC valid alone, address 0x1F000, 8 read beats with Last on beat 8 → o_MEM_Valid asserted from cycle 2; o_IC_Valid ×8; o_IC_Last once; DRAIN cycle; o_Burst_Error = 0.
- IC and DC valid in the same cycle, held, repeated 3 times → grant order IC, DC, IC, DC, IC, DC, with one DRAIN cycle between each.
- DC writeback (R/W_n = 0), data 0xA0..0xA7 → o_MEM_Data follows i_DC_Data; o_DC_Data_Read ×8; o_MEM_Read_Write_n = 0 for the whole burst.
- Read burst with Last on beat 6 → o_Burst_Error rises and stays 1 through later good bursts until reset.
- i_Reset_n low at beat 4 of a DC read → outputs reset asynchronously, state IDLE; a new IC request after reset is granted normally.
- Stray i_MEM_Valid in IDLE, and i_DC_Valid dropped mid-burst → no forwarding in IDLE; the DC burst still completes all 8 beats.
